mc8051_intc: RTL and testbench
==============================

// Module: mc8051_intc
// PURPOSE
//  Interrupt controller serving the CPU core's interrupt handshake (int_req_n/int_ack_n/int_so_num/int_reti).
//  Synchronises N_SRC peripheral requests and latches edge/level flags.
//  Arbitrates by 8051 two-level priority, presents one winner to the core and tracks in-service levels until RETI.
// PARAMETERS
//  N_SRC        5   number of interrupt sources (index 0 = highest natural priority)
//  SYNC_STAGES  2   synchroniser depth on i_src_irq (>=2)
// PORTS
//  clk           in   1      system clock, all logic rising-edge
//  reset         in   1      asynchronous, active-high reset
//  i_src_irq     in   N_SRC  raw peripheral requests, active-high, asynchronous
//  i_ea          in   1      global enable (IE.EA)
//  i_ie          in   N_SRC  per-source enable
//  i_ip          in   N_SRC  per-source priority, 1 = high
//  i_it          in   N_SRC  trigger type, 1 = rising edge, 0 = level
//  i_flag_clr    in   N_SRC  software clear of edge flags, one-cycle pulse
//  o_pending     out  N_SRC  pending flags for SFR readback
//  o_int_req_n   out  1      request to core, active-low
//  i_int_ack_n   in   1      acknowledge from core, active-low, one-cycle pulse
//  o_int_so_num  out  8      winning source index, zero-extended
//  i_int_reti    in   1      RETI executed, active-high, one-cycle pulse
//  o_isr_active  out  2      in-service bits {high, low}
// BEHAVIOUR
//  Reset: o_int_req_n=1, o_int_so_num=0, o_pending=0, o_isr_active=0, all sync/edge regs 0, FSM=IDLE.
//  Flags:
//   - edge source: flag sets on synchronised 0->1, cleared by ack of that source or i_flag_clr.
//   - level source: flag = synchronised level, no latching.
//   - Set beats clear in the same cycle (new edge + ack/flag_clr -> flag stays 1).
//  Latency: i_src_irq edge -> o_pending after SYNC_STAGES+1 clks; o_pending -> o_int_req_n low on the next clk.
//  Eligible = pending & ie & ea, masked by in-service:
//   - isr[1] set -> nothing eligible.
//   - isr[0] set -> only ip=1 sources eligible.
//  Arbitration: any eligible high-priority source beats low; within a level, lowest index wins.
//  FSM:
//   - IDLE: eligible winner exists -> REQ; register the winner into o_int_so_num; drive o_int_req_n=0.
//   - REQ, i_int_ack_n=0: clear edge flag of o_int_so_num; set isr[ip of winner]; o_int_req_n=1 next clk; -> IDLE.
//   - REQ, winner no longer eligible (level dropped, ie/ea cleared): o_int_req_n=1, -> IDLE. Re-arbitrate no earlier than the following clk.
//   - o_int_so_num holds stable throughout REQ. A higher source arriving during REQ does not replace the winner.
//  Ack while IDLE: ignored.
//  RETI: clears the highest set isr bit. With isr==0 it is ignored.
//  RETI and ack in the same clk: RETI clear applies first, then the ack's isr set.
//  Reset mid-handshake: everything returns to reset values immediately. A pending ack is lost.
// CONFIGURATION
//  MC8051_INTC_NEST_EN defined: two-level nesting as above (high preempts low in service).
//  MC8051_INTC_NEST_EN undefined:
//   - any isr bit set masks all sources.
//   - ack sets isr[0] only, and RETI clears it.
//   - ip still orders arbitration.
//   - o_isr_active[1] ties to 0.
// STRUCTURE
//  global_param.v holds INTC_IDLE/INTC_REQ state encodings and INTC_SO_NUM_W=8.
//  Sub-module mc8051_intc_sync: SYNC_STAGES flop chain plus rising-edge detect for one source.
//   - instantiated N_SRC times in a generate loop.
//   - reset to 0, so a source high at reset release yields one edge.
//  Top holds flag regs, priority encoder, FSM and isr regs.
// TESTING
//  1. Edge src 1 (ie=1, ea=1, it=1) pulses 3 clks -> o_pending[1]=1 at +3 clks, o_int_req_n=0 at +4, so_num=8'h01. Ack -> req_n=1, pending[1]=0, isr=2'b01.
//  2. Srcs 0 (ip=0) and 3 (ip=1) pending together -> so_num=8'h03 first. After ack, with NEST_EN, src 0 not requested until RETI -> isr=0, then so_num=8'h00.
//  3. NEST_EN: in service of src 2 (low), src 4 (ip=1) edge -> req with so_num=8'h04, isr=2'b11. Two RETIs -> isr 2'b01, then 2'b00. Without macro: src 4 held until first RETI.
//  4. Level src 0 asserted, req_n=0, then src deasserted before ack -> req_n=1 within 1 clk after pending drops; no isr set. Late ack ignored.
//  5. New edge on src 1 in the same clk as its ack -> pending[1] stays 1, re-request after isr cleared. i_flag_clr + edge same clk -> flag 1.
//  6. reset asserted while req_n=0 -> req_n=1, so_num=0, pending=0, isr=0 asynchronously.

Source files
------------

// File: rtl/mc8051_intc_pkg.sv
// Shared types and constants for the 8051 interrupt controller.
// Holds the handshake FSM encoding, the core-facing index width and the arbitration helper.
package mc8051_intc_pkg;

    localparam int unsigned INTC_SO_NUM_W = 8;
    localparam int unsigned INTC_MAX_SRC  = 32;

    typedef enum logic [0:0] {
        INTC_IDLE = 1'b0,
        INTC_REQ  = 1'b1
    } intc_state_e;

    // Index of the lowest set bit, 0 when the vector is empty.
    function automatic logic [INTC_SO_NUM_W-1:0] intc_lowest_idx(input logic [INTC_MAX_SRC-1:0] vec);
        logic [INTC_SO_NUM_W-1:0] idx;
        idx = '0;
        for (int i = int'(INTC_MAX_SRC) - 1; i >= 0; i--) begin
            if (vec[i]) idx = INTC_SO_NUM_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/mc8051_intc_sync.sv
// Per-source input synchroniser with rising-edge detect on the synchronised level.
// Resets to 0, so a source already high at reset release produces one edge.
module mc8051_intc_sync
    import mc8051_intc_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic i_irq,
    output logic o_level,
    output logic o_rise_c
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_irq};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_level  = r_sync[SYNC_STAGES-1];
    assign o_rise_c = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule

// File: rtl/mc8051_intc.sv
// 8051 interrupt controller: flag latching, two-level priority arbitration, core handshake, in-service tracking.
// Define MC8051_INTC_NEST_EN to let high-priority sources preempt a low-priority service routine.
module mc8051_intc
    import mc8051_intc_pkg::*;
#(
    parameter int unsigned N_SRC       = 5,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_SRC-1:0]         i_src_irq,
    input  logic                     i_ea,
    input  logic [N_SRC-1:0]         i_ie,
    input  logic [N_SRC-1:0]         i_ip,
    input  logic [N_SRC-1:0]         i_it,
    input  logic [N_SRC-1:0]         i_flag_clr,
    output logic [N_SRC-1:0]         o_pending,
    output logic                     o_int_req_n,
    input  logic                     i_int_ack_n,
    output logic [INTC_SO_NUM_W-1:0] o_int_so_num,
    input  logic                     i_int_reti,
    output logic [1:0]               o_isr_active
);

    logic [N_SRC-1:0]         w_level;
    logic [N_SRC-1:0]         w_rise;
    logic [N_SRC-1:0]         w_elig;
    logic [N_SRC-1:0]         w_elig_hi;
    logic [N_SRC-1:0]         w_win_sel;
    logic [N_SRC-1:0]         w_clr;
    logic [N_SRC-1:0]         w_pending_nxt;
    logic [INTC_SO_NUM_W-1:0] w_winner;
    logic [INTC_SO_NUM_W-1:0] w_so_num_nxt;
    logic [1:0]               w_isr_nxt;
    logic                     w_req_n_nxt;
    logic                     w_ack;
    intc_state_e              w_state_nxt;

    logic [N_SRC-1:0]         r_pending;
    logic [INTC_SO_NUM_W-1:0] r_so_num;
    logic [1:0]               r_isr;
    logic                     r_req_n;
    intc_state_e              r_state;

    for (genvar gi = 0; gi < N_SRC; gi++) begin : g_sync
        mc8051_intc_sync #(
            .SYNC_STAGES(SYNC_STAGES)
        ) u_sync (
            .clk      (clk),
            .reset    (reset),
            .i_irq    (i_src_irq[gi]),
            .o_level  (w_level[gi]),
            .o_rise_c (w_rise[gi])
        );
    end

    // Enabled pending sources, masked by whatever is currently in service.
    always_comb begin
        w_elig = r_pending & i_ie & {N_SRC{i_ea}};
`ifdef MC8051_INTC_NEST_EN
        if (r_isr[1])      w_elig = '0;
        else if (r_isr[0]) w_elig = w_elig & i_ip;
`else
        if (|r_isr)        w_elig = '0;
`endif
    end

    assign w_elig_hi = w_elig & i_ip;
    assign w_winner  = (|w_elig_hi) ? intc_lowest_idx(INTC_MAX_SRC'(w_elig_hi))
                                    : intc_lowest_idx(INTC_MAX_SRC'(w_elig));

    // One-hot view of the registered winner, avoids indexing with the 8-bit number.
    always_comb begin
        w_win_sel = '0;
        for (int i = 0; i < int'(N_SRC); i++) begin
            w_win_sel[i] = (r_so_num == INTC_SO_NUM_W'(i));
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_req_n_nxt  = r_req_n;
        w_so_num_nxt = r_so_num;
        w_ack        = 1'b0;
        case (r_state)
            INTC_IDLE: begin
                if (|w_elig) begin
                    w_state_nxt  = INTC_REQ;
                    w_req_n_nxt  = 1'b0;
                    w_so_num_nxt = w_winner;
                end
            end
            INTC_REQ: begin
                if (!i_int_ack_n) begin
                    w_ack       = 1'b1;
                    w_state_nxt = INTC_IDLE;
                    w_req_n_nxt = 1'b1;
                end else if (!(|(w_elig & w_win_sel))) begin
                    w_state_nxt = INTC_IDLE;
                    w_req_n_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = INTC_IDLE;
                w_req_n_nxt = 1'b1;
            end
        endcase
    end

    // Edge flags: a new edge outranks ack/software clear; level sources just follow the input.
    assign w_clr         = i_flag_clr | (w_ack ? w_win_sel : '0);
    assign w_pending_nxt = (i_it & (w_rise | (r_pending & ~w_clr))) | (~i_it & w_level);

    // RETI retires the highest active level before an ack in the same cycle marks a new one.
    always_comb begin
        w_isr_nxt = r_isr;
        if (i_int_reti) begin
            if (w_isr_nxt[1]) w_isr_nxt[1] = 1'b0;
            else              w_isr_nxt[0] = 1'b0;
        end
        if (w_ack) begin
`ifdef MC8051_INTC_NEST_EN
            if (|(i_ip & w_win_sel)) w_isr_nxt[1] = 1'b1;
            else                     w_isr_nxt[0] = 1'b1;
`else
            w_isr_nxt[0] = 1'b1;
`endif
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= INTC_IDLE;
            r_req_n   <= 1'b1;
            r_so_num  <= '0;
            r_pending <= '0;
            r_isr     <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_req_n   <= w_req_n_nxt;
            r_so_num  <= w_so_num_nxt;
            r_pending <= w_pending_nxt;
            r_isr     <= w_isr_nxt;
        end
    end

    assign o_pending    = r_pending;
    assign o_int_req_n  = r_req_n;
    assign o_int_so_num = r_so_num;
    assign o_isr_active = r_isr;

endmodule

// File: tb/tb_mc8051_intc.sv
// Directed and random checks of mc8051_intc against a cycle-level behavioural model.
// Honors MC8051_INTC_NEST_EN the same way the design does.
module tb_mc8051_intc;

    localparam int unsigned N = 5;
    localparam int unsigned S = 2;

    logic         clk;
    logic         reset;
    logic [N-1:0] src_irq;
    logic         ea;
    logic [N-1:0] ie;
    logic [N-1:0] ip;
    logic [N-1:0] it;
    logic [N-1:0] flag_clr;
    logic [N-1:0] o_pending;
    logic         o_int_req_n;
    logic         ack_n;
    logic [7:0]   o_int_so_num;
    logic         reti;
    logic [1:0]   o_isr_active;

    int n_vec;
    int n_err;

    // Reference state: input sample history (index 0 = newest), flags, request, winner, in-service.
    logic [N-1:0] m_hist [0:S];
    logic [N-1:0] m_pend;
    logic         m_req;
    logic [7:0]   m_so;
    logic [1:0]   m_isr;

    mc8051_intc #(.N_SRC(N), .SYNC_STAGES(S)) dut (
        .clk          (clk),
        .reset        (reset),
        .i_src_irq    (src_irq),
        .i_ea         (ea),
        .i_ie         (ie),
        .i_ip         (ip),
        .i_it         (it),
        .i_flag_clr   (flag_clr),
        .o_pending    (o_pending),
        .o_int_req_n  (o_int_req_n),
        .i_int_ack_n  (ack_n),
        .o_int_so_num (o_int_so_num),
        .i_int_reti   (reti),
        .o_isr_active (o_isr_active)
    );

    always #5 clk = ~clk;

    function automatic int pick(input logic [N-1:0] el, input logic [N-1:0] pr);
        for (int i = 0; i < int'(N); i++) if (el[i] && pr[i]) return i;
        for (int i = 0; i < int'(N); i++) if (el[i]) return i;
        return 0;
    endfunction

    task automatic model_reset();
        for (int k = 0; k <= int'(S); k++) m_hist[k] = '0;
        m_pend = '0;
        m_req  = 1'b0;
        m_so   = 8'h00;
        m_isr  = 2'b00;
    endtask

    task automatic model_step();
        logic [N-1:0] lvl, rise, el, np, sel;
        logic         ack;
        logic [1:0]   ni;
        int           so;
        so   = int'(m_so);
        sel  = N'(1) << so;
        lvl  = m_hist[S-1];
        rise = lvl & ~m_hist[S];
        el   = m_pend & ie & {N{ea}};
`ifdef MC8051_INTC_NEST_EN
        if (m_isr[1])      el = '0;
        else if (m_isr[0]) el = el & ip;
`else
        if (m_isr != 2'b00) el = '0;
`endif
        ack = m_req && (ack_n == 1'b0);
        ni  = m_isr;
        if (reti) ni = (ni >= 2'd2) ? ni - 2'd2 : 2'd0;
`ifdef MC8051_INTC_NEST_EN
        if (ack) ni = ni | ((|(ip & sel)) ? 2'b10 : 2'b01);
`else
        if (ack) ni = ni | 2'b01;
`endif
        for (int i = 0; i < int'(N); i++) begin
            if (!it[i])                             np[i] = lvl[i];
            else if (rise[i])                       np[i] = 1'b1;
            else if (flag_clr[i] || (ack && i == so)) np[i] = 1'b0;
            else                                    np[i] = m_pend[i];
        end
        if (m_req) begin
            if (ack || !(|(el & sel))) m_req = 1'b0;
        end else if (|el) begin
            m_req = 1'b1;
            m_so  = 8'(pick(el, ip));
        end
        for (int k = int'(S); k > 0; k--) m_hist[k] = m_hist[k-1];
        m_hist[0] = src_irq;
        m_pend    = np;
        m_isr     = ni;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_req_n"}, 8'(o_int_req_n), m_req ? 8'h00 : 8'h01);
        chk({tag, "_so"},    o_int_so_num,    m_so);
        chk({tag, "_pend"},  8'(o_pending),   8'(m_pend));
        chk({tag, "_isr"},   8'(o_isr_active), 8'(m_isr));
    endtask

    task automatic tick(input int n);
        for (int c = 0; c < n; c++) begin
            @(posedge clk);
            if (reset) model_reset();
            else       model_step();
            @(negedge clk);
            check_all("cyc");
        end
    endtask

    task automatic pulse_ack();
        ack_n = 1'b0; tick(1); ack_n = 1'b1;
    endtask

    task automatic pulse_reti();
        reti = 1'b1; tick(1); reti = 1'b0;
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        clk = 1'b0; reset = 1'b0;
        src_irq = '0; ea = 1'b1; ie = '1; ip = '0; it = '1; flag_clr = '0;
        ack_n = 1'b1; reti = 1'b0;
        model_reset();
        #1 reset = 1'b1;
        #1 check_all("reset");
        tick(2);
        reset = 1'b0;
        tick(2);

        // 1: edge source 1 latency and ack
        src_irq[1] = 1'b1;
        tick(2); chk("t1_pend_early", 8'(o_pending), 8'h00);
        tick(1); chk("t1_pend", 8'(o_pending), 8'h02); chk("t1_req_early", 8'(o_int_req_n), 8'h01);
        src_irq[1] = 1'b0;
        tick(1); chk("t1_req", 8'(o_int_req_n), 8'h00); chk("t1_so", o_int_so_num, 8'h01);
        pulse_ack();
        chk("t1_ack_req", 8'(o_int_req_n), 8'h01);
        chk("t1_ack_pend", 8'(o_pending), 8'h00);
        chk("t1_ack_isr", 8'(o_isr_active), 8'h01);
        pulse_reti();
        chk("t1_reti_isr", 8'(o_isr_active), 8'h00);

        // 2: high-priority source 3 beats source 0
        ip = 5'b01000;
        src_irq[0] = 1'b1; src_irq[3] = 1'b1;
        tick(4); chk("t2_so", o_int_so_num, 8'h03);
        pulse_ack();
`ifdef MC8051_INTC_NEST_EN
        chk("t2_isr", 8'(o_isr_active), 8'h02);
`else
        chk("t2_isr", 8'(o_isr_active), 8'h01);
`endif
        tick(3); chk("t2_masked", 8'(o_int_req_n), 8'h01);
        pulse_reti();
        tick(1); chk("t2_req0", 8'(o_int_req_n), 8'h00); chk("t2_so0", o_int_so_num, 8'h00);
        pulse_ack(); pulse_reti();
        src_irq = '0;

        // 3: high source arriving while a low one is in service
        ip = 5'b10000;
        src_irq[2] = 1'b1;
        tick(4); chk("t3_so2", o_int_so_num, 8'h02);
        pulse_ack(); chk("t3_isr_lo", 8'(o_isr_active), 8'h01);
        src_irq[4] = 1'b1;
        tick(4);
`ifdef MC8051_INTC_NEST_EN
        chk("t3_preempt", 8'(o_int_req_n), 8'h00); chk("t3_so4", o_int_so_num, 8'h04);
        pulse_ack(); chk("t3_isr_both", 8'(o_isr_active), 8'h03);
        pulse_reti(); chk("t3_reti1", 8'(o_isr_active), 8'h01);
        pulse_reti(); chk("t3_reti2", 8'(o_isr_active), 8'h00);
`else
        chk("t3_held", 8'(o_int_req_n), 8'h01);
        pulse_reti(); chk("t3_reti1", 8'(o_isr_active), 8'h00);
        tick(1); chk("t3_req4", 8'(o_int_req_n), 8'h00); chk("t3_so4", o_int_so_num, 8'h04);
        pulse_ack(); pulse_reti();
`endif
        src_irq = '0; ip = '0;

        // 4: level source withdraws before ack
        it = 5'b11110;
        src_irq[0] = 1'b1;
        tick(4); chk("t4_req", 8'(o_int_req_n), 8'h00); chk("t4_so", o_int_so_num, 8'h00);
        src_irq[0] = 1'b0;
        tick(3); chk("t4_pend_drop", 8'(o_pending), 8'h00);
        tick(1); chk("t4_withdraw", 8'(o_int_req_n), 8'h01);
        pulse_ack(); chk("t4_late_ack", 8'(o_isr_active), 8'h00);
        it = '1;
        tick(2);

        // 5: new edge coincident with ack, then with software clear
        src_irq[1] = 1'b1;
        tick(4); chk("t5_so", o_int_so_num, 8'h01);
        src_irq[1] = 1'b0; tick(2);
        src_irq[1] = 1'b1; tick(2);
        pulse_ack();
        chk("t5_pend_kept", 8'(o_pending), 8'h02); chk("t5_isr", 8'(o_isr_active), 8'h01);
        pulse_reti();
        tick(1); chk("t5_rereq", 8'(o_int_req_n), 8'h00); chk("t5_reso", o_int_so_num, 8'h01);
        pulse_ack(); chk("t5_cleared", 8'(o_pending), 8'h00);
        pulse_reti();
        src_irq[1] = 1'b0; tick(2);
        src_irq[1] = 1'b1; tick(2);
        flag_clr = 5'b00010; tick(1); flag_clr = '0;
        chk("t5_clr_vs_edge", 8'(o_pending), 8'h02);
        tick(1); pulse_ack(); pulse_reti();
        src_irq = '0; tick(2);

        // 6: asynchronous reset mid-handshake, source held through release
        src_irq[3] = 1'b1;
        tick(4); chk("t6_req", 8'(o_int_req_n), 8'h00);
        #2 reset = 1'b1;
        #1 model_reset();
        chk("t6_rst_req", 8'(o_int_req_n), 8'h01);
        chk("t6_rst_so", o_int_so_num, 8'h00);
        chk("t6_rst_pend", 8'(o_pending), 8'h00);
        chk("t6_rst_isr", 8'(o_isr_active), 8'h00);
        tick(2);
        reset = 1'b0;
        tick(4); chk("t6_rel_req", 8'(o_int_req_n), 8'h00); chk("t6_rel_so", o_int_so_num, 8'h03);
        pulse_ack(); pulse_reti();

        // Random traffic against the model
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 5) == 0) src_irq[$urandom_range(0, N-1)] ^= 1'b1;
            flag_clr = ($urandom_range(0, 15) == 0) ? N'($urandom) : '0;
            ack_n    = (ack_n == 1'b0) ? 1'b1 : ($urandom_range(0, 3) != 0);
            reti     = !reti && ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 99) == 0) begin
                ie = N'($urandom) | N'($urandom);
                ip = N'($urandom);
                it = N'($urandom);
                ea = ($urandom_range(0, 7) != 0);
            end
            tick(1);
        end

        src_irq = '0; flag_clr = '0; ack_n = 1'b1; reti = 1'b0;
        tick(2);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
